// File: rtl/dw_conv_pkg.sv
// Shared definitions for the XDMA width converters (up- and down-conversion paths).
package dw_conv_pkg;

    localparam int XDMA_WIDE_DW   = 512;
    localparam int XDMA_NARROW_DW = 64;

    // Beat-index register width; a ratio of 1 still gets a 1-bit counter.
    function automatic int beat_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/dw_beat_counter.sv
// Beat index counter with synchronous clear and a wrap flag at the final beat.
module dw_beat_counter
    import dw_conv_pkg::*;
#(
    parameter int RATIO = 8,
    parameter int W     = beat_cnt_w(RATIO)
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST_Q = W'(RATIO - 1);

    logic [W-1:0] q_r;

    assign q    = q_r;
    assign wrap = (q_r == LAST_Q);

    // Beat index; with RATIO==1 the index can never leave zero.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            q_r <= '0;
        end else if (clear) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= wrap ? '0 : (q_r + W'(1));
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/dw_down_converter.sv
// Wide-to-narrow width converter: splits each wide word into DOWN_RATIO beats, LSB slice first.
module dw_down_converter
    import dw_conv_pkg::*;
#(
    parameter int INPUT_DW   = XDMA_WIDE_DW,
    parameter int OUTPUT_DW  = XDMA_NARROW_DW,
    parameter int DOWN_RATIO = INPUT_DW / OUTPUT_DW
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [INPUT_DW-1:0]  data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [OUTPUT_DW-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o,
    input  logic                 ready_i
);

    localparam int CNT_W = beat_cnt_w(DOWN_RATIO);

    if (((INPUT_DW % OUTPUT_DW) != 0) || (OUTPUT_DW > INPUT_DW)) begin : g_bad_cfg
        $fatal(1, "dw_down_converter: INPUT_DW must be an integer multiple of OUTPUT_DW");
    end

    logic [INPUT_DW-1:0]  buf_r;
    logic                 full_r;
    logic [CNT_W-1:0]     cnt_s;
    logic                 wrap_s;
    logic                 in_acc_s;
    logic                 beat_acc_s;
    logic [OUTPUT_DW-1:0] data_mux_s;

    assign valid_o    = full_r;
    assign last_o     = full_r && wrap_s;
    assign data_o     = data_mux_s;
    // Taking the final beat frees the buffer in the same cycle, so a new word loads without a gap.
    assign ready_o    = !rst_i && (!full_r || (ready_i && last_o));
    assign in_acc_s   = valid_i && ready_o;
    assign beat_acc_s = full_r && ready_i;

    dw_beat_counter #(
        .RATIO (DOWN_RATIO),
        .W     (CNT_W)
    ) u_beat_counter (
        .clk   (clk),
        .rst_i (rst_i),
        .clear (in_acc_s),
        .en    (beat_acc_s),
        .q     (cnt_s),
        .wrap  (wrap_s)
    );

    // Select the narrow slice addressed by the current beat index.
    always_comb begin
        data_mux_s = '0;
        for (int i = 0; i < DOWN_RATIO; i++) begin
            if (cnt_s == CNT_W'(i)) begin
                data_mux_s = buf_r[i*OUTPUT_DW +: OUTPUT_DW];
            end else begin
                data_mux_s = data_mux_s;
            end
        end
    end

    // Wide word buffer, loaded only on an input handshake.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            buf_r <= '0;
        end else if (in_acc_s) begin
            buf_r <= data_i;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Buffer occupancy: set on load, cleared once the last beat leaves with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            full_r <= 1'b0;
        end else if (in_acc_s) begin
            full_r <= 1'b1;
        end else if (beat_acc_s && last_o) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

endmodule

// File: tb/tb_dw_down_converter.sv
// Directed bench for dw_down_converter: 512->64 instance plus a 64->64 register-slice instance.
module tb_dw_down_converter;

    logic         clk;
    logic         rst_i;
    logic [511:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic [63:0]  data_o;
    logic         valid_o;
    logic         last_o;
    logic         ready_i;

    logic [63:0]  d1_data_i;
    logic         d1_valid_i;
    logic         d1_ready_o;
    logic [63:0]  d1_data_o;
    logic         d1_valid_o;
    logic         d1_last_o;
    logic         d1_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    dw_down_converter #(.INPUT_DW(512), .OUTPUT_DW(64)) dut (
        .clk(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i)
    );

    dw_down_converter #(.INPUT_DW(64), .OUTPUT_DW(64)) dut1 (
        .clk(clk), .rst_i(rst_i), .data_i(d1_data_i), .valid_i(d1_valid_i), .ready_o(d1_ready_o),
        .data_o(d1_data_o), .valid_o(d1_valid_o), .last_o(d1_last_o), .ready_i(d1_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk_word(input logic [63:0] base);
        logic [511:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = base + 64'(k);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] exp_q[$];
        logic [63:0] e;
        logic [63:0] prev_data;
        logic        prev_last;
        logic        prev_stall;
        int          sent;
        int          rcv;

        rst_i = 1'b1; valid_i = 1'b1; data_i = mk_word(64'd100); ready_i = 1'b0;
        d1_valid_i = 1'b0; d1_data_i = 64'd0; d1_ready_i = 1'b0;

        // 1. reset held three cycles with valid_i high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_ready", {63'd0, ready_o}, 64'd0);
            chk("rst_valid", {63'd0, valid_o}, 64'd0);
            chk("rst_last", {63'd0, last_o}, 64'd0);
            chk("rst_data", data_o, 64'd0);
            chk("rst_d1_valid", {63'd0, d1_valid_o}, 64'd0);
        end
        @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
        chk("post_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("post_rst_d1_ready", {63'd0, d1_ready_o}, 64'd1);

        // 2. single word, beat k carries value k
        @(negedge clk);
        valid_i = 1'b1; data_i = mk_word(64'd0); ready_i = 1'b1;
        #1;
        chk("single_accept_ready", {63'd0, ready_o}, 64'd1);
        chk("single_accept_valid", {63'd0, valid_o}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            chk("single_valid", {63'd0, valid_o}, 64'd1);
            chk("single_data", data_o, 64'(k));
            chk("single_last", {63'd0, last_o}, (k == 7) ? 64'd1 : 64'd0);
        end
        @(negedge clk); #1;
        chk("single_idle", {63'd0, valid_o}, 64'd0);

        // 3. four words back to back, no gap
        @(negedge clk);
        valid_i = 1'b1; data_i = mk_word(64'h100); ready_i = 1'b1;
        #1;
        chk("b2b_first_ready", {63'd0, ready_o}, 64'd1);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            data_i  = mk_word(64'h100 * 64'((n - 1) / 8 + 2));
            valid_i = (((n - 1) / 8) < 3);
            #1;
            chk("b2b_valid", {63'd0, valid_o}, 64'd1);
            chk("b2b_data", data_o, 64'h100 * 64'((n - 1) / 8 + 1) + 64'((n - 1) % 8));
            chk("b2b_last", {63'd0, last_o}, (((n - 1) % 8) == 7) ? 64'd1 : 64'd0);
            chk("b2b_ready", {63'd0, ready_o}, (((n - 1) % 8) == 7) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("b2b_idle", {63'd0, valid_o}, 64'd0);

        // 4. random backpressure, in-order scoreboard
        for (int w = 1; w <= 3; w++)
            for (int k = 0; k < 8; k++) exp_q.push_back(64'h1000 * 64'(w) + 64'(k));
        sent = 0; rcv = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 400 && rcv < 24; cyc++) begin
            @(negedge clk);
            ready_i = 1'($urandom % 2);
            valid_i = (sent < 3);
            data_i  = mk_word(64'h1000 * 64'(sent + 1));
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", {63'd0, valid_o}, 64'd1);
                chk("bp_hold_data", data_o, prev_data);
                chk("bp_hold_last", {63'd0, last_o}, {63'd0, prev_last});
            end
            if (valid_o && ready_i) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead;
                chk("bp_data", data_o, e);
                chk("bp_last", {63'd0, last_o}, (e[2:0] == 3'd7) ? 64'd1 : 64'd0);
                rcv++;
            end
            if (valid_i && ready_o) sent++;
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
        end
        chk("bp_beat_count", 64'(rcv), 64'd24);
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("bp_drained", {63'd0, valid_o}, 64'd0);

        // 5. reset in the middle of word A, then word B
        @(negedge clk);
        valid_i = 1'b1; data_i = mk_word(64'h500); ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            chk("mid_a_data", data_o, 64'h500 + 64'(k));
        end
        @(negedge clk);
        rst_i = 1'b1; ready_i = 1'b0; valid_i = 1'b1; data_i = mk_word(64'h700);
        #1;
        chk("mid_rst_ready", {63'd0, ready_o}, 64'd0);
        chk("mid_rst_data", data_o, 64'h504);
        @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("mid_after_valid", {63'd0, valid_o}, 64'd0);
        chk("mid_after_data", data_o, 64'd0);
        @(negedge clk);
        valid_i = 1'b1; data_i = mk_word(64'h600);
        #1;
        chk("mid_b_ready", {63'd0, ready_o}, 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            chk("mid_b_valid", {63'd0, valid_o}, 64'd1);
            chk("mid_b_data", data_o, 64'h600 + 64'(k));
            chk("mid_b_last", {63'd0, last_o}, (k == 7) ? 64'd1 : 64'd0);
        end
        @(negedge clk); #1;
        chk("mid_idle", {63'd0, valid_o}, 64'd0);

        // 6. ratio 1 instance streaming 1..16 with stalls on both sides
        sent = 0; rcv = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 300 && rcv < 16; cyc++) begin
            @(negedge clk);
            d1_valid_i = (sent < 16) && 1'($urandom % 2);
            d1_data_i  = 64'(sent + 1);
            d1_ready_i = 1'($urandom % 2);
            #1;
            chk("r1_last_eq_valid", {63'd0, d1_last_o}, {63'd0, d1_valid_o});
            if (prev_stall) begin
                chk("r1_hold_valid", {63'd0, d1_valid_o}, 64'd1);
                chk("r1_hold_data", d1_data_o, prev_data);
            end
            if (d1_valid_o && d1_ready_i) begin
                chk("r1_data", d1_data_o, 64'(rcv + 1));
                rcv++;
            end
            if (d1_valid_i && d1_ready_o) sent++;
            prev_stall = d1_valid_o && !d1_ready_i;
            prev_data  = d1_data_o;
        end
        chk("r1_beat_count", 64'(rcv), 64'd16);
        d1_valid_i = 1'b0; d1_ready_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
